// File: rtl/fp_to_fixed_stream.sv
// IEEE-754 single to signed fixed-point converter, two-stage valid/ready pipeline.
// S1 decodes and aligns the magnitude (one guard bit kept); S2 rounds, range-checks, negates and saturates.
module fp_to_fixed_stream #(
  parameter int INT_BITS  = 3,
  parameter int FRAC_BITS = 16,
  parameter int PI_LIMIT  = 1
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [31:0]                   in_data,
  input  logic                          in_sat,
  input  logic                          in_rnd,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [INT_BITS+FRAC_BITS-1:0] out_data,
  output logic                          out_invalid,
  output logic                          out_ovf,
  output logic [7:0]                    err_cnt,
  input  logic                          cnt_clr
);

  localparam int W  = INT_BITS + FRAC_BITS;
  // Aligned magnitude width: 24-bit mantissa shifted left by at most W+1, plus headroom.
  localparam int VW = W + 26;
  localparam logic [30:0] PI_ABS = 31'h40490FDB;

  // Fixed-point magnitude of pi (mantissa 0xC90FDB, exponent 1) under either rounding mode.
  function automatic logic [VW-1:0] pi_mag_f(input logic rnd);
    logic [127:0] v;
    int           s;
    s = FRAC_BITS - 21;
    if (s >= 0) v = 128'(24'hC90FDB) << s;
    else        v = 128'(24'hC90FDB) >> (-s);
    v = (v >> 1) + ((rnd && v[0]) ? 128'd1 : 128'd0);
    return v[VW-1:0];
  endfunction

  localparam logic [VW-1:0] MAX_POS = (VW'(1) << (W - 1)) - VW'(1);
  localparam logic [VW-1:0] MAX_NEG = VW'(1) << (W - 1);
  localparam logic [VW-1:0] PI_T    = pi_mag_f(1'b0);
  localparam logic [VW-1:0] PI_R    = pi_mag_f(1'b1);
  localparam logic [VW-1:0] SPT_V = (PI_LIMIT != 0 && PI_T < MAX_POS) ? PI_T : MAX_POS;
  localparam logic [VW-1:0] SPR_V = (PI_LIMIT != 0 && PI_R < MAX_POS) ? PI_R : MAX_POS;
  localparam logic [VW-1:0] SNT_V = (PI_LIMIT != 0 && PI_T < MAX_NEG) ? PI_T : MAX_NEG;
  localparam logic [VW-1:0] SNR_V = (PI_LIMIT != 0 && PI_R < MAX_NEG) ? PI_R : MAX_NEG;
  localparam logic [W-1:0]  SAT_POS_T = SPT_V[W-1:0];
  localparam logic [W-1:0]  SAT_POS_R = SPR_V[W-1:0];
  localparam logic [W-1:0]  SAT_NEG_T = SNT_V[W-1:0];
  localparam logic [W-1:0]  SAT_NEG_R = SNR_V[W-1:0];

  // Handshake: a word moves across an interface on a rising edge where valid & ready are
  // both high; valid never depends on ready, and a stalled output holds its word unchanged.
  logic s1_v_q, s1_v_d;
  logic s2_load, in_fire, out_fire;
  logic out_valid_q, out_valid_d;

  assign s2_load  = s1_v_q & (~out_valid_q | out_ready);
  assign in_ready = ~s1_v_q | s2_load;
  assign in_fire  = in_valid & in_ready;
  assign out_fire = out_valid_q & out_ready;

  // ---------------- S1: decode / classify / align ----------------
  logic [7:0]        dec_exp, dec_eeff;
  logic [22:0]       dec_frac;
  logic [23:0]       dec_mant;
  logic signed [11:0] dec_sh;
  logic [11:0]       dec_nsh;
  logic              dec_nan, dec_inf, dec_big, dec_piov;
  logic [VW-1:0]     dec_val;

  always_comb begin
    dec_exp  = in_data[30:23];
    dec_frac = in_data[22:0];
    dec_nan  = (dec_exp == 8'hFF) && (dec_frac != 23'd0);
    dec_inf  = (dec_exp == 8'hFF) && (dec_frac == 23'd0);
    dec_mant = (dec_exp == 8'd0) ? {1'b0, dec_frac} : {1'b1, dec_frac};
    dec_eeff = (dec_exp == 8'd0) ? 8'd1 : dec_exp;
    // Shift that places value*2^(FRAC_BITS+1) (one guard bit) at integer position.
    dec_sh   = $signed({4'b0, dec_eeff}) + $signed(12'(FRAC_BITS + 1 - 150));
    dec_nsh  = -dec_sh;
    dec_big  = dec_sh > $signed(12'(W + 1));
    dec_piov = in_data[30:0] > PI_ABS;
    dec_val  = '0;
    if (dec_sh >= 12'sd0) dec_val = VW'(dec_mant) << dec_sh[10:0];
    else                  dec_val = VW'(dec_mant) >> dec_nsh;
  end

  logic          s1_sign_q, s1_nan_q, s1_inf_q, s1_big_q, s1_piov_q, s1_sat_q, s1_rnd_q;
  logic [VW-1:0] s1_val_q;

  always_comb begin
    s1_v_d = s1_v_q;
    if (in_fire)      s1_v_d = 1'b1;
    else if (s2_load) s1_v_d = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_v_q    <= 1'b0;
      s1_sign_q <= 1'b0;
      s1_nan_q  <= 1'b0;
      s1_inf_q  <= 1'b0;
      s1_big_q  <= 1'b0;
      s1_piov_q <= 1'b0;
      s1_sat_q  <= 1'b0;
      s1_rnd_q  <= 1'b0;
      s1_val_q  <= '0;
    end else begin
      s1_v_q <= s1_v_d;
      if (in_fire) begin
        s1_sign_q <= in_data[31];
        s1_nan_q  <= dec_nan;
        s1_inf_q  <= dec_inf;
        s1_big_q  <= dec_big;
        s1_piov_q <= dec_piov;
        s1_sat_q  <= in_sat;
        s1_rnd_q  <= in_rnd;
        s1_val_q  <= dec_val;
      end
    end
  end

  // ---------------- S2: round / range-check / negate / saturate ----------------
  logic [VW-1:0] mag_t, mag_r;
  logic          mag_over, oor;
  logic [W-1:0]  sat_mag, sel_mag;
  logic [W-1:0]  out_data_d;
  logic          out_invalid_d, out_ovf_d;

  always_comb begin
    mag_t    = s1_val_q >> 1;
    mag_r    = mag_t + VW'(s1_rnd_q & s1_val_q[0]);
    mag_over = s1_sign_q ? (mag_r > MAX_NEG) : (mag_r > MAX_POS);
    oor      = s1_inf_q | s1_big_q | mag_over | ((PI_LIMIT != 0) & s1_piov_q);
    if (s1_sign_q) sat_mag = s1_rnd_q ? SAT_NEG_R : SAT_NEG_T;
    else           sat_mag = s1_rnd_q ? SAT_POS_R : SAT_POS_T;
    sel_mag       = oor ? sat_mag : mag_r[W-1:0];
    out_data_d    = s1_sign_q ? (~sel_mag + W'(1)) : sel_mag;
    out_invalid_d = 1'b0;
    out_ovf_d     = 1'b0;
    if (s1_nan_q || (oor && !s1_sat_q)) begin
      out_data_d    = '0;
      out_invalid_d = 1'b1;
    end else if (oor) begin
      out_ovf_d = 1'b1;
    end
  end

  always_comb begin
    out_valid_d = out_valid_q;
    if (s2_load)       out_valid_d = 1'b1;
    else if (out_fire) out_valid_d = 1'b0;
  end

  logic [W-1:0] out_data_q;
  logic         out_invalid_q, out_ovf_q;
  logic [7:0]   err_cnt_q, err_cnt_d;

  always_comb begin
    err_cnt_d = err_cnt_q;
    if (cnt_clr)
      err_cnt_d = 8'd0;
    else if (out_fire && (out_invalid_q || out_ovf_q) && err_cnt_q != 8'hFF)
      err_cnt_d = err_cnt_q + 8'd1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid_q   <= 1'b0;
      out_data_q    <= '0;
      out_invalid_q <= 1'b0;
      out_ovf_q     <= 1'b0;
      err_cnt_q     <= 8'd0;
    end else begin
      out_valid_q <= out_valid_d;
      err_cnt_q   <= err_cnt_d;
      if (s2_load) begin
        out_data_q    <= out_data_d;
        out_invalid_q <= out_invalid_d;
        out_ovf_q     <= out_ovf_d;
      end
    end
  end

  assign out_valid   = out_valid_q;
  assign out_data    = out_data_q;
  assign out_invalid = out_invalid_q;
  assign out_ovf     = out_ovf_q;
  assign err_cnt     = err_cnt_q;

endmodule

// File: doc/fp_to_fixed_stream.md
FP_TO_FIXED_STREAM -- requirements
Module: fp_to_fixed_stream

Interface
REQ-001 SHALL have parameter INT_BITS, default 3, meaning integer bits of the output including sign.
REQ-002 SHALL have parameter FRAC_BITS, default 16, meaning fractional bits of the output; W = INT_BITS+FRAC_BITS.
REQ-003 SHALL have parameter PI_LIMIT, default 1, meaning when 1, |x| > pi (0x40490FDB) is out of range regardless of W.
REQ-004 SHALL have ports, in order: clk in 1 (sole clock, rising edge); rst_n in 1 (synchronous, active-low reset); in_valid in 1 (input word present); in_ready out 1 (block accepts input); in_data in 32 (IEEE-754 single); in_sat in 1 (1 = saturate out-of-range, 0 = flag invalid and output zero); in_rnd in 1 (0 = truncate toward zero, 1 = round half away from zero); out_valid out 1; out_ready in 1; out_data out W (two's-complement fixed point); out_invalid out 1; out_ovf out 1 (result saturated); err_cnt out 8 (saturating error count); cnt_clr in 1 (synchronous counter clear).

Function
REQ-005 SHALL transfer input on cycles with in_valid & in_ready, and output on cycles with out_valid & out_ready.
REQ-006 SHALL be a 2-stage pipeline: S1 decode/classify/align magnitude, S2 round/range-check/negate/saturate; latency is exactly 2 cycles from input transfer to out_valid when out_ready is held high.
REQ-007 SHALL sustain one transfer per cycle when out_ready is held high.
REQ-008 SHALL advance each stage only if it is empty or the next stage advances this cycle; in_ready = S1 empty or S1 advances.
REQ-009 SHALL hold out_data, out_invalid and out_ovf stable while out_valid & ~out_ready.
REQ-010 SHALL sample in_sat and in_rnd with the input word and carry them down the pipeline; mode changes never affect in-flight words.
REQ-011 SHALL compute R = x * 2^FRAC_BITS, magnitude truncated (in_rnd=0) or rounded half away from zero (in_rnd=1), then negated if sign=1.
REQ-012 SHALL treat subnormals as value frac * 2^-149 and either-signed zero as result 0, no flags.
REQ-013 SHALL classify out of range: rounded magnitude > 2^(W-1)-1 (positive) or > 2^(W-1) (negative), infinity, or PI_LIMIT=1 and |x| > pi; exactly pi is in range.
REQ-014 SHALL for NaN output 0, out_invalid=1, out_ovf=0, regardless of in_sat.
REQ-015 SHALL for out-of-range with sat=0 output 0, out_invalid=1, out_ovf=0.
REQ-016 SHALL for out-of-range with sat=1 output 2^(W-1)-1 (x>0) or -2^(W-1) (x<0), except with PI_LIMIT=1 clamp to +/-R(pi) under the word's rounding mode, with out_ovf=1, out_invalid=0.
REQ-017 SHALL keep all internal shift/round arithmetic wide enough that no intermediate wraps for any exponent 0..254.
REQ-018 SHALL increment err_cnt by 1 on each output transfer with out_invalid or out_ovf set, saturating at 255.
REQ-019 SHALL give cnt_clr priority over a simultaneous increment (err_cnt becomes 0).
REQ-020 SHALL keep err_cnt unchanged by backpressure stalls (counting only on transfer).

Reset
REQ-021 SHALL on rst_n=0 at a clock edge clear both stage valids, out_valid=0, out_data=0, out_invalid=0, out_ovf=0, err_cnt=0.
REQ-022 SHALL discard in-flight words on reset mid-operation; in_ready=1 in the first cycle after rst_n returns high.
REQ-023 SHALL ignore in_valid while rst_n=0.

Verification (defaults INT_BITS=3, FRAC_BITS=16, PI_LIMIT=1)
REQ-024 SHALL cover: 0x3F800000 rnd=0, out_ready=1 -> out_data 0x10000 exactly 2 cycles later, no flags; 0xBFC00000 -> 0x68000.
REQ-025 SHALL cover: 0x40490FDB (pi) rnd=0 and rnd=1 -> 0x3243F both, no flags; 0x37000000 (2^-17) rnd=0 -> 0x00000, rnd=1 -> 0x00001.
REQ-026 SHALL cover: 0x40800000 (4.0) sat=0 -> 0, out_invalid=1, err_cnt 0->1; sat=1 -> 0x3243F, out_ovf=1, err_cnt 1->2; 0xC0800000 sat=1 -> 0x4DBC1.
REQ-027 SHALL cover: 0x7FC00000 sat=1 -> 0, out_invalid=1; 300 NaN transfers -> err_cnt=255; cnt_clr coincident with an error transfer -> err_cnt=0.
REQ-028 SHALL cover: out_ready low 4 cycles while streaming 1.0, 2.0, 3.0 -> in_ready drops after 2 words held, out_data 0x10000 held stable, then 0x10000, 0x20000, 0x30000 delivered in order with no loss or duplication.
REQ-029 SHALL cover: rst_n low for 1 cycle with two words in flight -> out_valid=0 next cycle, err_cnt=0, neither word ever emitted.
